axis_pkt_fifo: RTL

- Synchronous AXI4-Stream packet FIFO between the stream master and the stream slave in the AXI-Stream top.
- Buffers beats (tdata + tlast) so downstream back-pressure does not stall the producer.
- Reports occupancy and the count of complete stored packets.
- Plain FIFO by default; store-and-forward packet mode selectable at compile time.

---
 rtl/axis_pkt_fifo_pkg.sv | 20 ++
 rtl/axis_fifo_mem.sv | 29 ++
 rtl/axis_pkt_fifo.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/axis_pkt_fifo_pkg.sv
// Shared types and constants for the AXI4-Stream packet FIFO.
package axis_pkt_fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;

  // One stored beat: tlast kept alongside tdata.
  typedef struct packed {
    logic                  last;
    logic [DATA_W_DEF-1:0] data;
  } axis_beat_t;

  // Pointer width: index bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int PTR_W_DEF = $clog2(DEPTH_DEF) + 1;

endpackage

// File: rtl/axis_fifo_mem.sv
// Register-array storage for the packet FIFO: one synchronous write port,
// one asynchronous read port, no reset on the contents.
module axis_fifo_mem
  import axis_pkt_fifo_pkg::*;
#(
  parameter int W     = DATA_W_DEF + 1,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // Store the incoming beat when the write port is enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI4-Stream packet FIFO with occupancy and complete-packet counters.
// Compile-time option AXIS_PKT_FIFO_STORE_FWD_EN selects store-and-forward:
// the head is only presented once a whole packet (a tlast beat) is stored,
// or in cut-through when the FIFO fills without one (oversize goes sticky).
//
// Handshake: a beat transfers on a rising clk edge where tvalid && tready.
// s_axis_tready depends only on FIFO state, never on s_axis_tvalid;
// m_axis_tvalid depends only on FIFO state, never on m_axis_tready, and the
// head beat stays stable while m_axis_tvalid=1 and m_axis_tready=0.
module axis_pkt_fifo
  import axis_pkt_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic [DATA_W-1:0]          s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     pkt_count,
  output logic                       oversize
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic [PW-1:0] pkt_count_q, pkt_count_d;
  logic          running_q, running_d;

  logic          empty;
  logic          full;
  logic          pkt_ready;
  logic          wr_en;
  logic          rd_en;
  logic          wr_last;
  logic          rd_last;
  logic [DATA_W:0] rd_beat;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // running_q holds tready low until the first edge after reset release.
  assign s_axis_tready = running_q && !full;
  assign wr_en         = s_axis_tvalid && s_axis_tready;
  assign wr_last       = wr_en && s_axis_tlast;

  axis_fifo_mem #(
    .W     (DATA_W + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata ({s_axis_tlast, s_axis_tdata}),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_beat)
  );

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
  logic oversize_q, oversize_d;

  // Release when a whole packet is stored, or when full to avoid deadlock.
  assign pkt_ready = (pkt_count_q != '0) || full;

  // Oversize latches the first time the FIFO fills with no complete packet.
  always_comb begin
    oversize_d = oversize_q;
    if (full && (pkt_count_q == '0)) begin
      oversize_d = 1'b1;
    end
  end

  // Sticky oversize flag, cleared only by reset.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      oversize_q <= 1'b0;
    end else begin
      oversize_q <= oversize_d;
    end
  end

  assign oversize = oversize_q;
`else
  assign pkt_ready = 1'b1;
  assign oversize  = 1'b0;
`endif

  assign m_axis_tvalid = !empty && pkt_ready;
  assign rd_en         = m_axis_tvalid && m_axis_tready;
  assign rd_last       = rd_en && rd_beat[DATA_W];

  // Head beat straight from storage; forced to zero until out of reset.
  assign m_axis_tdata = running_q ? rd_beat[DATA_W-1:0] : '0;
  assign m_axis_tlast = running_q ? rd_beat[DATA_W]     : 1'b0;

  assign count     = count_q;
  assign pkt_count = pkt_count_q;

  // Next-state for pointers and counters from the two handshakes.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pkt_count_d = pkt_count_q;
    running_d   = 1'b1;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase

    unique case ({wr_last, rd_last})
      2'b10:   pkt_count_d = pkt_count_q + PW'(1);
      2'b01:   pkt_count_d = pkt_count_q - PW'(1);
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  // State registers; reset discards every stored beat at once.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_count_q <= '0;
      running_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pkt_count_q <= pkt_count_d;
      running_q   <= running_d;
    end
  end

endmodule
